// File: rtl/simple_axi_master.sv
// Single-beat AXI4 master: a host issues one read or write at a time and
// gets sticky done/invalid/error flags back until it acknowledges them.
module simple_axi_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  input  logic [1:0]              i_rw,
  output logic                    o_wait,
  output logic                    o_done,
  input  logic                    i_clear_done,
  output logic                    o_invalid,
  output logic                    o_error,
  output logic                    o_axi_awvalid,
  input  logic                    i_axi_awready,
  output logic [ADDR_WIDTH-1:0]   o_axi_awaddr,
  output logic [2:0]              o_axi_awsize,
  output logic [1:0]              o_axi_awburst,
  output logic [3:0]              o_axi_awcache,
  output logic [2:0]              o_axi_awprot,
  output logic [7:0]              o_axi_awlen,
  output logic                    o_axi_awlock,
  output logic [3:0]              o_axi_awqos,
  output logic                    o_axi_wvalid,
  input  logic                    i_axi_wready,
  output logic                    o_axi_wlast,
  output logic [DATA_WIDTH-1:0]   o_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] o_axi_wstrb,
  input  logic                    i_axi_bvalid,
  output logic                    o_axi_bready,
  input  logic [1:0]              i_axi_bresp,
  output logic                    o_axi_arvalid,
  input  logic                    i_axi_arready,
  output logic [ADDR_WIDTH-1:0]   o_axi_araddr,
  output logic [2:0]              o_axi_arsize,
  output logic [1:0]              o_axi_arburst,
  output logic [3:0]              o_axi_arcache,
  output logic [2:0]              o_axi_arprot,
  output logic [7:0]              o_axi_arlen,
  output logic                    o_axi_arlock,
  output logic [3:0]              o_axi_arqos,
  input  logic                    i_axi_rvalid,
  output logic                    o_axi_rready,
  input  logic                    i_axi_rlast,
  input  logic [DATA_WIDTH-1:0]   i_axi_rdata,
  input  logic [1:0]              i_axi_rresp
);
  localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH/8));

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic aw_pend, w_pend, rerr;

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt     = state;
    o_wait        = 1'b0;
    o_axi_awvalid = 1'b0;
    o_axi_wvalid  = 1'b0;
    o_axi_bready  = 1'b0;
    o_axi_arvalid = 1'b0;
    o_axi_rready  = 1'b0;
    case (state)
      IDLE:
        if (!o_done)
          case (i_rw)
            2'b01:   state_nxt = WRITE;
            2'b10:   state_nxt = RADDR;
            2'b11:   state_nxt = DONE;
            default: state_nxt = IDLE;
          endcase
      WRITE: begin
        o_wait        = 1'b1;
        o_axi_awvalid = aw_pend;
        o_axi_wvalid  = w_pend;
        // AW and W retire independently; move on only when neither is pending
        if ((!aw_pend || i_axi_awready) && (!w_pend || i_axi_wready))
          state_nxt = WRESP;
      end
      WRESP: begin
        o_wait       = 1'b1;
        o_axi_bready = 1'b1;
        if (i_axi_bvalid) state_nxt = DONE;
      end
      RADDR: begin
        o_wait        = 1'b1;
        o_axi_arvalid = 1'b1;
        if (i_axi_arready) state_nxt = RDATA;
      end
      RDATA: begin
        o_wait       = 1'b1;
        o_axi_rready = 1'b1;
        if (i_axi_rvalid && i_axi_rlast) state_nxt = DONE;
      end
      DONE:
        if (i_clear_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      o_rdata   <= '0;
      o_done    <= 1'b0;
      o_invalid <= 1'b0;
      o_error   <= 1'b0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      rerr      <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (!o_done)
            case (i_rw)
              2'b01: begin
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
              end
              2'b10: begin
                addr_q <= i_addr;
                rerr   <= 1'b0;
              end
              2'b11: begin
                o_invalid <= 1'b1;
                o_done    <= 1'b1;
              end
              default: ;
            endcase
        WRITE: begin
          if (i_axi_awready) aw_pend <= 1'b0;
          if (i_axi_wready)  w_pend  <= 1'b0;
        end
        WRESP:
          if (i_axi_bvalid) begin
            o_error <= |i_axi_bresp;
            o_done  <= 1'b1;
          end
        RDATA:
          // an error on any beat of the burst sticks through to the last beat
          if (i_axi_rvalid) begin
            o_rdata <= i_axi_rdata;
            rerr    <= rerr | (|i_axi_rresp);
            if (i_axi_rlast) begin
              o_error <= rerr | (|i_axi_rresp);
              o_done  <= 1'b1;
            end
          end
        DONE:
          if (i_clear_done) begin
            o_done    <= 1'b0;
            o_invalid <= 1'b0;
            o_error   <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  assign o_axi_awaddr  = addr_q;
  assign o_axi_araddr  = addr_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = '1;
  assign o_axi_wlast   = 1'b1;
  assign o_axi_awsize  = SIZE;
  assign o_axi_arsize  = SIZE;
  assign o_axi_awburst = 2'b01;
  assign o_axi_arburst = 2'b01;
  assign o_axi_awcache = 4'b0011;
  assign o_axi_arcache = 4'b0011;
  assign o_axi_awprot  = 3'b000;
  assign o_axi_arprot  = 3'b000;
  assign o_axi_awlen   = 8'd0;
  assign o_axi_arlen   = 8'd0;
  assign o_axi_awlock  = 1'b0;
  assign o_axi_arlock  = 1'b0;
  assign o_axi_awqos   = 4'd0;
  assign o_axi_arqos   = 4'd0;
endmodule

// File: tb/tb_simple_axi_master.sv
// Bench for simple_axi_master: transaction-level model checked every cycle,
// a configurable stalling slave, and directed host scenarios.
module tb_simple_axi_master;
  logic        i_clk = 0, i_rst = 0;
  logic [31:0] i_addr = 0, i_wdata = 0;
  logic [31:0] o_rdata;
  logic [1:0]  i_rw = 0;
  logic        o_wait, o_done, i_clear_done = 0, o_invalid, o_error;
  logic        o_axi_awvalid, i_axi_awready = 0, o_axi_awlock;
  logic [31:0] o_axi_awaddr, o_axi_araddr, o_axi_wdata;
  logic [2:0]  o_axi_awsize, o_axi_arsize, o_axi_awprot, o_axi_arprot;
  logic [1:0]  o_axi_awburst, o_axi_arburst;
  logic [3:0]  o_axi_awcache, o_axi_arcache, o_axi_awqos, o_axi_arqos, o_axi_wstrb;
  logic [7:0]  o_axi_awlen, o_axi_arlen;
  logic        o_axi_wvalid, i_axi_wready = 0, o_axi_wlast;
  logic        i_axi_bvalid = 0, o_axi_bready;
  logic [1:0]  i_axi_bresp = 0, i_axi_rresp = 0;
  logic        o_axi_arvalid, i_axi_arready = 0, o_axi_arlock;
  logic        i_axi_rvalid = 0, o_axi_rready, i_axi_rlast = 0;
  logic [31:0] i_axi_rdata = 0;

  simple_axi_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .i_rw(i_rw), .o_wait(o_wait), .o_done(o_done), .i_clear_done(i_clear_done),
    .o_invalid(o_invalid), .o_error(o_error),
    .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready), .o_axi_awaddr(o_axi_awaddr),
    .o_axi_awsize(o_axi_awsize), .o_axi_awburst(o_axi_awburst), .o_axi_awcache(o_axi_awcache),
    .o_axi_awprot(o_axi_awprot), .o_axi_awlen(o_axi_awlen), .o_axi_awlock(o_axi_awlock),
    .o_axi_awqos(o_axi_awqos),
    .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready), .o_axi_wlast(o_axi_wlast),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
    .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready), .i_axi_bresp(i_axi_bresp),
    .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready), .o_axi_araddr(o_axi_araddr),
    .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst), .o_axi_arcache(o_axi_arcache),
    .o_axi_arprot(o_axi_arprot), .o_axi_arlen(o_axi_arlen), .o_axi_arlock(o_axi_arlock),
    .o_axi_arqos(o_axi_arqos),
    .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready), .i_axi_rlast(i_axi_rlast),
    .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp)
  );

  always #5 i_clk = ~i_clk;

  int npass = 0, ntot = 0;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // slave configuration (written by the scenario only)
  int  aw_dly = 1, w_dly = 1, ar_dly = 1, b_dly = 1, r_dly = 1, r_n = 1, r_base = 0;
  bit  aw_early = 0;
  logic [1:0]  b_resp_cfg = 0;
  logic [31:0] r_data [2];
  logic [1:0]  r_resp [2];

  // handshake monitor (sole writer of these counters)
  int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_hs_n = 0, valid_n = 0;
  logic [31:0] seen_awaddr = 0, seen_wdata = 0, seen_araddr = 0;
  always @(posedge i_clk) if (!i_rst) begin
    if (o_axi_awvalid || o_axi_wvalid || o_axi_arvalid) valid_n++;
    if (o_axi_awvalid && i_axi_awready) begin aw_n++; seen_awaddr = o_axi_awaddr; end
    if (o_axi_wvalid && i_axi_wready) begin w_n++; seen_wdata = o_axi_wdata; end
    if (o_axi_arvalid && i_axi_arready) begin ar_n++; seen_araddr = o_axi_araddr; end
    if (o_axi_bready && i_axi_bvalid) b_n++;
    if (o_axi_rready && i_axi_rvalid) r_hs_n++;
  end

  // slave: ready/valid driven on the falling edge from the DUT's current outputs
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, b_seen = 0, r_seen = 0;
  always @(negedge i_clk) begin
    if (i_rst) begin
      i_axi_awready = 0; i_axi_wready = 0; i_axi_arready = 0; i_axi_bvalid = 0; i_axi_rvalid = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; b_seen = b_n; r_seen = r_hs_n;
    end else begin
      i_axi_awready = aw_early || (o_axi_awvalid && aw_cnt >= aw_dly);
      aw_cnt = o_axi_awvalid ? aw_cnt + 1 : 0;
      i_axi_wready = o_axi_wvalid && w_cnt >= w_dly;
      w_cnt = o_axi_wvalid ? w_cnt + 1 : 0;
      i_axi_arready = o_axi_arvalid && ar_cnt >= ar_dly;
      ar_cnt = o_axi_arvalid ? ar_cnt + 1 : 0;
      if (b_seen != b_n) begin i_axi_bvalid = 0; b_seen = b_n; b_cnt = 0; end
      else if (o_axi_bready && !i_axi_bvalid) begin
        if (b_cnt >= b_dly) begin i_axi_bvalid = 1; i_axi_bresp = b_resp_cfg; end
        b_cnt++;
      end
      if (r_seen != r_hs_n) begin i_axi_rvalid = 0; r_seen = r_hs_n; r_cnt = 0; end
      if (o_axi_rready && !i_axi_rvalid && (r_hs_n - r_base) < r_n) begin
        if (r_cnt >= r_dly) begin
          i_axi_rvalid = 1;
          i_axi_rdata  = r_data[r_hs_n - r_base];
          i_axi_rresp  = r_resp[r_hs_n - r_base];
          i_axi_rlast  = (r_hs_n - r_base) == r_n - 1;
        end
        r_cnt++;
      end
    end
  end

  // transaction-level model: one outstanding op, each channel tracked by a done flag
  localparam int OP_NONE = 0, OP_WR = 1, OP_RD = 2;
  int m_op = OP_NONE;
  bit m_aw_ok = 0, m_w_ok = 0, m_ar_ok = 0, m_done = 0, m_inv = 0, m_err = 0, m_rerr = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_op = OP_NONE; m_done = 0; m_inv = 0; m_err = 0; m_rdata = 0;
    end else if (m_done) begin
      if (i_clear_done) begin m_done = 0; m_inv = 0; m_err = 0; end
    end else if (m_op == OP_NONE) begin
      if (i_rw == 2'b01) begin m_op = OP_WR; m_addr = i_addr; m_wdata = i_wdata; m_aw_ok = 0; m_w_ok = 0; end
      else if (i_rw == 2'b10) begin m_op = OP_RD; m_addr = i_addr; m_ar_ok = 0; m_rerr = 0; end
      else if (i_rw == 2'b11) begin m_inv = 1; m_done = 1; end
    end else if (m_op == OP_WR) begin
      if (m_aw_ok && m_w_ok) begin
        if (i_axi_bvalid) begin m_err = i_axi_bresp != 0; m_done = 1; m_op = OP_NONE; end
      end else begin
        if (i_axi_awready) m_aw_ok = 1;
        if (i_axi_wready) m_w_ok = 1;
      end
    end else begin
      if (!m_ar_ok) begin
        if (i_axi_arready) m_ar_ok = 1;
      end else if (i_axi_rvalid) begin
        m_rdata = i_axi_rdata;
        if (i_axi_rresp != 0) m_rerr = 1;
        if (i_axi_rlast) begin m_err = m_rerr; m_done = 1; m_op = OP_NONE; end
      end
    end
  end

  always @(posedge i_clk) begin
    #1;
    chk("wait", 64'(o_wait), 64'(m_op != OP_NONE));
    chk("done", 64'(o_done), 64'(m_done));
    chk("invalid", 64'(o_invalid), 64'(m_inv));
    chk("error", 64'(o_error), 64'(m_err));
    chk("rdata", 64'(o_rdata), 64'(m_rdata));
    chk("awvalid", 64'(o_axi_awvalid), 64'(m_op == OP_WR && !m_aw_ok));
    chk("wvalid", 64'(o_axi_wvalid), 64'(m_op == OP_WR && !m_w_ok));
    chk("bready", 64'(o_axi_bready), 64'(m_op == OP_WR && m_aw_ok && m_w_ok));
    chk("arvalid", 64'(o_axi_arvalid), 64'(m_op == OP_RD && !m_ar_ok));
    chk("rready", 64'(o_axi_rready), 64'(m_op == OP_RD && m_ar_ok));
    if (m_op == OP_WR && !m_aw_ok) chk("awaddr", 64'(o_axi_awaddr), 64'(m_addr));
    if (m_op == OP_WR && !m_w_ok) chk("wdata", 64'(o_axi_wdata), 64'(m_wdata));
    if (m_op == OP_RD && !m_ar_ok) chk("araddr", 64'(o_axi_araddr), 64'(m_addr));
  end

  task automatic do_cmd(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] d);
    @(negedge i_clk); i_rw = rw; i_addr = a; i_wdata = d;
    @(negedge i_clk); i_rw = 2'b00;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!o_done && n < 60) begin @(negedge i_clk); n++; end
    chk(name, 64'(o_done), 64'd1);
  endtask

  task automatic clear();
    @(negedge i_clk); i_clear_done = 1;
    @(negedge i_clk); i_clear_done = 0;
    chk("clear_done", 64'(o_done), 64'd0);
    chk("clear_err", 64'(o_error), 64'd0);
    chk("clear_inv", 64'(o_invalid), 64'd0);
  endtask

  int base;
  initial begin
    #1 i_rst = 1;
    repeat (2) @(negedge i_clk);
    chk("rst_wait", 64'(o_wait), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_valids", 64'({o_axi_awvalid, o_axi_wvalid, o_axi_arvalid}), 64'd0);
    chk("rst_readys", 64'({o_axi_bready, o_axi_rready}), 64'd0);
    chk("rst_rdata", 64'(o_rdata), 64'd0);
    chk("c_size", 64'({o_axi_awsize, o_axi_arsize}), 64'o22);
    chk("c_burst", 64'({o_axi_awburst, o_axi_arburst}), 64'b0101);
    chk("c_cache", 64'({o_axi_awcache, o_axi_arcache}), 64'h33);
    chk("c_misc", 64'({o_axi_awprot, o_axi_arprot, o_axi_awlen, o_axi_arlen,
                       o_axi_awlock, o_axi_arlock, o_axi_awqos, o_axi_arqos}), 64'd0);
    chk("c_wlast_strb", 64'({o_axi_wlast, o_axi_wstrb}), 64'h1F);
    i_rst = 0;

    // write, slave ready one cycle after valid, OKAY response
    do_cmd(2'b01, 32'h1000_0000, 32'hCAFE_BABE);
    wait_done("wr1_done");
    chk("wr1_awaddr", 64'(seen_awaddr), 64'h1000_0000);
    chk("wr1_wdata", 64'(seen_wdata), 64'hCAFE_BABE);
    chk("wr1_error", 64'(o_error), 64'd0);
    clear();
    chk("clr_wait", 64'(o_wait), 64'd0);

    // read, then hold i_rw in DONE: no second address phase
    r_data[0] = 32'hDEAD_BEEF; r_resp[0] = 2'b00; r_n = 1; r_base = r_hs_n;
    base = ar_n;
    do_cmd(2'b10, 32'h2000_0000, 32'h0);
    wait_done("rd1_done");
    chk("rd1_araddr", 64'(seen_araddr), 64'h2000_0000);
    chk("rd1_rdata", 64'(o_rdata), 64'hDEAD_BEEF);
    @(negedge i_clk); i_rw = 2'b10;
    repeat (5) @(negedge i_clk);
    chk("hold_no_rd", 64'(ar_n - base), 64'd1);
    chk("hold_done", 64'(o_done), 64'd1);
    i_rw = 2'b00;
    clear();

    // invalid command: no AXI activity; a read held across clear is then accepted
    base = valid_n;
    do_cmd(2'b11, 32'h0, 32'h0);
    wait_done("inv_done");
    chk("inv_flag", 64'(o_invalid), 64'd1);
    repeat (3) @(negedge i_clk);
    chk("inv_no_valid", 64'(valid_n - base), 64'd0);
    r_data[0] = 32'h5A5A_5A5A; r_base = r_hs_n; base = ar_n;
    @(negedge i_clk); i_clear_done = 1; i_rw = 2'b10; i_addr = 32'h3000_0000;
    @(negedge i_clk); i_clear_done = 0;
    @(negedge i_clk); i_rw = 2'b00;
    wait_done("acc_done");
    chk("acc_rd", 64'(ar_n - base), 64'd1);
    chk("acc_rdata", 64'(o_rdata), 64'h5A5A_5A5A);
    clear();

    // write with early AWREADY, slow W, SLVERR response
    aw_early = 1; w_dly = 3; b_dly = 2; b_resp_cfg = 2'b10;
    do_cmd(2'b01, 32'h0000_0040, 32'h1234_5678);
    wait_done("wr2_done");
    chk("wr2_error", 64'(o_error), 64'd1);
    chk("wr2_wdata", 64'(seen_wdata), 64'h1234_5678);
    aw_early = 0; w_dly = 1; b_resp_cfg = 2'b00;
    clear();

    // two-beat read, error on the first beat only
    r_data[0] = 32'h1111_1111; r_resp[0] = 2'b10;
    r_data[1] = 32'h2222_2222; r_resp[1] = 2'b00;
    r_n = 2; r_dly = 0; ar_dly = 2; r_base = r_hs_n;
    do_cmd(2'b10, 32'h0000_0080, 32'h0);
    wait_done("rd2_done");
    chk("rd2_rdata", 64'(o_rdata), 64'h2222_2222);
    chk("rd2_error", 64'(o_error), 64'd1);
    clear();

    // async reset while waiting for the write response
    b_dly = 20;
    do_cmd(2'b01, 32'h0000_00C0, 32'hFFFF_0000);
    begin
      int n = 0;
      while (!o_axi_bready && n < 30) begin @(negedge i_clk); n++; end
    end
    chk("wresp_reached", 64'(o_axi_bready), 64'd1);
    #2 i_rst = 1;
    #1;
    chk("arst_bready", 64'(o_axi_bready), 64'd0);
    chk("arst_wait", 64'(o_wait), 64'd0);
    chk("arst_rdata", 64'(o_rdata), 64'd0);
    chk("arst_flags", 64'({o_done, o_invalid, o_error}), 64'd0);
    chk("arst_valids", 64'({o_axi_awvalid, o_axi_wvalid, o_axi_arvalid, o_axi_rready}), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 0;
    repeat (3) @(negedge i_clk);
    chk("post_rst_idle", 64'(o_wait), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/simple_axi_master.md
SIMPLE_AXI_MASTER -- requirements
Module: simple_axi_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have i_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have i_addr  in  ADDR_WIDTH  host transfer address.
REQ-006 SHALL have i_wdata  in  DATA_WIDTH  host write data.
REQ-007 SHALL have o_rdata  out  DATA_WIDTH  last read data.
REQ-008 SHALL have i_rw  in  2  command: 00 none, 01 write, 10 read, 11 invalid.
REQ-009 SHALL have o_wait  out  1  transfer in progress.
REQ-010 SHALL have o_done  out  1  sticky completion flag.
REQ-011 SHALL have i_clear_done  in  1  clears o_done/o_invalid/o_error.
REQ-012 SHALL have o_invalid  out  1  sticky: illegal command (i_rw=11).
REQ-013 SHALL have o_error  out  1  sticky: non-OKAY response.
REQ-014 SHALL have o_axi_awvalid/o_axi_arvalid out 1, i_axi_awready/i_axi_arready in 1, o_axi_awaddr/o_axi_araddr out ADDR_WIDTH.
REQ-015 SHALL have o_axi_awsize/o_axi_arsize out 3, o_axi_awburst/o_axi_arburst out 2, o_axi_awcache/o_axi_arcache out 4, o_axi_awprot/o_axi_arprot out 3, o_axi_awlen/o_axi_arlen out 8, o_axi_awlock/o_axi_arlock out 1, o_axi_awqos/o_axi_arqos out 4.
REQ-016 SHALL have o_axi_wvalid out 1, i_axi_wready in 1, o_axi_wlast out 1, o_axi_wdata out DATA_WIDTH, o_axi_wstrb out DATA_WIDTH/8.
REQ-017 SHALL have i_axi_bvalid in 1, o_axi_bready out 1, i_axi_bresp in 2.
REQ-018 SHALL have i_axi_rvalid in 1, o_axi_rready out 1, i_axi_rlast in 1, i_axi_rdata in DATA_WIDTH, i_axi_rresp in 2.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE (AW+W), WRESP, RADDR, RDATA, DONE.
REQ-020 SHALL, in IDLE with o_done=0: on i_rw=01 latch i_addr/i_wdata, go WRITE; on 10 latch i_addr, go RADDR; on 11 set o_invalid and o_done, go DONE, no AXI activity; on 00 stay.
REQ-021 SHALL assert awvalid and wvalid the cycle after acceptance; each drops the cycle after its own valid&ready handshake, independently; WRESP entered once both have completed.
REQ-022 SHALL hold awaddr/araddr/wdata stable while the corresponding valid is high.
REQ-023 SHALL assert bready in WRESP until bvalid; then latch o_error = (bresp!=00), set o_done, go DONE.
REQ-024 SHALL assert arvalid in RADDR until arready handshake, then go RDATA with rready high.
REQ-025 SHALL in RDATA capture i_axi_rdata into o_rdata on each rvalid beat; on rvalid&&rlast set o_error if any beat rresp!=00, set o_done, go DONE.
REQ-026 SHALL drive o_wait=1 in WRITE, WRESP, RADDR, RDATA; 0 otherwise.
REQ-027 SHALL stay in DONE, ignoring i_rw, until i_clear_done=1, then clear o_done/o_invalid/o_error and return IDLE next cycle; a still-asserted i_rw is then accepted as new command.
REQ-028 SHALL ignore i_clear_done outside DONE.
REQ-029 SHALL drive constants: size=log2(DATA_WIDTH/8) (010 at 32 bit), burst=01 INCR, cache=0011, prot=000, len=0, lock=0, qos=0, wlast=1, wstrb all ones.
REQ-030 SHALL tolerate ready asserted before or after valid and arbitrary slave stall lengths.

Reset
REQ-031 SHALL on i_rst=1 immediately force IDLE, all valid/ready outputs 0, o_rdata=0, o_done/o_wait/o_invalid/o_error=0, aborting any transfer.

Verification
REQ-032 Write: addr 0x10000000, wdata 0xCAFEBABE, rw=01, slave ready one cycle after valid, bresp 00 -> AW/W show those values, o_done=1, o_error=0.
REQ-033 Read: addr 0x20000000, rw=10, slave returns 0xDEADBEEF rlast=1 rresp 00 -> araddr 0x20000000, o_rdata=0xDEADBEEF, o_done=1.
REQ-034 clear_done pulse with rw=00 -> o_done 0, IDLE; rw held high in DONE causes no second transfer.
REQ-035 rw=11 -> o_invalid=1, o_done=1, no valid asserted; bresp=10 -> o_error=1.
REQ-036 i_rst asserted during WRESP -> all outputs at reset values without clock edge.
